// File: rtl/ps2_pkg.sv
`timescale 1ns/1ps
// ps2_pkg
// Shared definitions for the PS/2 host transmitter and receiver:
//   - ps2_state_t : transfer state encoding
//   - BIT_CNT_W   : width of the data/parity bit counter
//   - inhibit_cycles / timeout_cycles : timing counts derived from the clock
//   - count_width : width of a counter that must hold 0 .. n-1
package ps2_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_INHIBIT   = 3'd1,
        ST_REQ       = 3'd2,
        ST_SHIFT     = 3'd3,
        ST_STOP      = 3'd4,
        ST_ACK       = 3'd5,
        ST_WAIT_IDLE = 3'd6
    } ps2_state_t;

    localparam int BIT_CNT_W = 4;

    // Clock cycles spent holding the PS/2 clock low before a request.
    function automatic longint unsigned inhibit_cycles(input longint unsigned clk_hz,
                                                       input longint unsigned us);
        return (clk_hz * us) / 64'd1000000;
    endfunction

    // Clock cycles allowed from clock release to end of transfer.
    function automatic longint unsigned timeout_cycles(input longint unsigned clk_hz,
                                                       input longint unsigned ms);
        return (clk_hz * ms) / 64'd1000;
    endfunction

    function automatic int count_width(input longint unsigned n);
        return (n <= 64'd2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
`timescale 1ns/1ps
// ps2_sync_edge
// Two-flop synchronizer for one raw PS/2 line plus a falling-edge detector
// on the synchronized level.
//   clk   : system clock
//   srst  : synchronous active-high reset (flops reset to the idle level 1)
//   line  : raw asynchronous line level
//   level : synchronized line level
//   fall  : one-cycle strobe when the synchronized level goes 1 -> 0
module ps2_sync_edge (
    input  logic clk,
    input  logic srst,
    input  logic line,
    output logic level,
    output logic fall
);

    logic meta_reg;
    logic sync_reg;
    logic prev_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            meta_reg <= 1'b1;
            sync_reg <= 1'b1;
            prev_reg <= 1'b1;
        end else begin
            meta_reg <= line;
            sync_reg <= meta_reg;
            prev_reg <= sync_reg;
        end
    end

    assign level = sync_reg;
    assign fall  = prev_reg & ~sync_reg;

endmodule

// File: rtl/ps2_host_tx.sv
`timescale 1ns/1ps
// ps2_host_tx
// PS/2 host-to-device command transmitter. Inhibits the bus, issues the
// request-to-send, shifts out {parity, data} LSB first on device clock
// falling edges, releases for the stop bit, checks the device acknowledge
// and waits for the bus to go idle. A timeout covers every phase after the
// clock is released.
//   CLOCK_50   : system clock
//   RESET      : synchronous active-high reset
//   TX_DATA    : command byte, captured on TX_VALID & TX_READY
//   TX_VALID   : request valid
//   TX_READY   : high only while idle
//   PS2_CLK_IN : raw PS/2 clock level
//   PS2_DAT_IN : raw PS/2 data level
//   PS2_CLK_OE : 1 pulls PS/2 clock low
//   PS2_DAT_OE : 1 pulls PS/2 data low
//   TX_DONE    : one-cycle pulse, transfer acknowledged
//   TX_ERROR   : one-cycle pulse, no acknowledge or timeout
module ps2_host_tx
    import ps2_pkg::*;
#(
    parameter int unsigned CLK_FREQ_HZ = 50000000,
    parameter int unsigned INHIBIT_US  = 100,
    parameter int unsigned TIMEOUT_MS  = 15
) (
    input  logic       CLOCK_50,
    input  logic       RESET,
    input  logic [7:0] TX_DATA,
    input  logic       TX_VALID,
    output logic       TX_READY,
    input  logic       PS2_CLK_IN,
    input  logic       PS2_DAT_IN,
    output logic       PS2_CLK_OE,
    output logic       PS2_DAT_OE,
    output logic       TX_DONE,
    output logic       TX_ERROR
);

    localparam longint unsigned INH_CYC = inhibit_cycles(CLK_FREQ_HZ, INHIBIT_US);
    localparam longint unsigned TO_CYC  = timeout_cycles(CLK_FREQ_HZ, TIMEOUT_MS);
    localparam int INH_W = count_width(INH_CYC);
    localparam int TO_W  = count_width(TO_CYC);

    localparam logic [INH_W-1:0] INH_LAST = INH_W'(INH_CYC - 64'd1);
    // Start bit goes out one cycle before the clock is released.
    localparam logic [INH_W-1:0] DAT_AT   = INH_W'((INH_CYC >= 64'd2) ? INH_CYC - 64'd2 : 64'd0);
    localparam logic [TO_W-1:0]  TO_LAST  = TO_W'(TO_CYC - 64'd1);
    localparam logic [BIT_CNT_W-1:0] PARITY_IDX = BIT_CNT_W'(8);

    // Index 0 is the clock line, index 1 the data line.
    logic [1:0] line_raw;
    logic [1:0] line_level;
    logic [1:0] line_fall;
    logic       unused_dat_fall;

    assign line_raw        = {PS2_DAT_IN, PS2_CLK_IN};
    assign unused_dat_fall = line_fall[1];

    genvar gi;
    generate
        for (gi = 0; gi < 2; gi++) begin : g_sync
            ps2_sync_edge u_sync (
                .clk   (CLOCK_50),
                .srst  (RESET),
                .line  (line_raw[gi]),
                .level (line_level[gi]),
                .fall  (line_fall[gi])
            );
        end
    endgenerate

    logic clk_level;
    logic dat_level;
    logic clk_fall;

    assign clk_level = line_level[0];
    assign dat_level = line_level[1];
    assign clk_fall  = line_fall[0];

    ps2_state_t           state_reg;
    logic [8:0]           frame_reg;     // {parity, data}
    logic [BIT_CNT_W-1:0] bit_cnt_reg;
    logic [BIT_CNT_W-1:0] bit_next;
    logic [INH_W-1:0]     inh_cnt_reg;
    logic [TO_W-1:0]      to_cnt_reg;
    logic                 clk_oe_reg;
    logic                 dat_oe_reg;
    logic                 ready_reg;
    logic                 done_reg;
    logic                 error_reg;

    assign bit_next = bit_cnt_reg + BIT_CNT_W'(1);

    always_ff @(posedge CLOCK_50) begin
        if (RESET) begin
            state_reg   <= ST_IDLE;
            frame_reg   <= '0;
            bit_cnt_reg <= '0;
            inh_cnt_reg <= '0;
            to_cnt_reg  <= '0;
            clk_oe_reg  <= 1'b0;
            dat_oe_reg  <= 1'b0;
            ready_reg   <= 1'b0;
            done_reg    <= 1'b0;
            error_reg   <= 1'b0;
        end else begin
            done_reg  <= 1'b0;
            error_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    clk_oe_reg <= 1'b0;
                    dat_oe_reg <= 1'b0;
                    ready_reg  <= 1'b1;
                    if (TX_VALID && ready_reg) begin
                        frame_reg   <= {~^TX_DATA, TX_DATA};
                        ready_reg   <= 1'b0;
                        clk_oe_reg  <= 1'b1;
                        inh_cnt_reg <= '0;
                        state_reg   <= ST_INHIBIT;
                    end
                end

                ST_INHIBIT: begin
                    if (inh_cnt_reg == DAT_AT) begin
                        dat_oe_reg <= 1'b1;
                    end
                    if (inh_cnt_reg == INH_LAST) begin
                        clk_oe_reg <= 1'b0;
                        to_cnt_reg <= '0;
                        state_reg  <= ST_REQ;
                    end else begin
                        inh_cnt_reg <= inh_cnt_reg + INH_W'(1);
                    end
                end

                default: begin
                    // REQ through WAIT_IDLE: the timeout outranks any edge.
                    if (to_cnt_reg == TO_LAST) begin
                        clk_oe_reg <= 1'b0;
                        dat_oe_reg <= 1'b0;
                        error_reg  <= 1'b1;
                        ready_reg  <= 1'b1;
                        state_reg  <= ST_IDLE;
                    end else begin
                        to_cnt_reg <= to_cnt_reg + TO_W'(1);
                        case (state_reg)
                            ST_REQ: begin
                                if (clk_fall) begin
                                    dat_oe_reg  <= ~frame_reg[0];
                                    bit_cnt_reg <= '0;
                                    state_reg   <= ST_SHIFT;
                                end
                            end
                            ST_SHIFT: begin
                                if (clk_fall) begin
                                    if (bit_cnt_reg == PARITY_IDX) begin
                                        dat_oe_reg <= 1'b0;
                                        state_reg  <= ST_STOP;
                                    end else begin
                                        bit_cnt_reg <= bit_next;
                                        dat_oe_reg  <= ~frame_reg[bit_next];
                                    end
                                end
                            end
                            ST_STOP: begin
                                if (clk_fall) begin
                                    state_reg <= ST_ACK;
                                end
                            end
                            ST_ACK: begin
                                if (clk_fall) begin
                                    if (!dat_level) begin
                                        state_reg <= ST_WAIT_IDLE;
                                    end else begin
                                        error_reg <= 1'b1;
                                        ready_reg <= 1'b1;
                                        state_reg <= ST_IDLE;
                                    end
                                end
                            end
                            ST_WAIT_IDLE: begin
                                if (clk_level && dat_level) begin
                                    done_reg  <= 1'b1;
                                    ready_reg <= 1'b1;
                                    state_reg <= ST_IDLE;
                                end
                            end
                            default: begin
                                clk_oe_reg <= 1'b0;
                                dat_oe_reg <= 1'b0;
                                state_reg  <= ST_IDLE;
                            end
                        endcase
                    end
                end
            endcase
        end
    end

    assign TX_READY   = ready_reg;
    assign PS2_CLK_OE = clk_oe_reg;
    assign PS2_DAT_OE = dat_oe_reg;
    assign TX_DONE    = done_reg;
    assign TX_ERROR   = error_reg;

endmodule

// File: tb/tb_ps2_host_tx.sv
`timescale 1ns/1ps
// tb_ps2_host_tx
// Directed and randomized host-to-device transfers against an open-drain
// PS/2 device model. Expected frames are built from the byte value with
// plain arithmetic (start 0, data LSB first, odd parity, stop 1).
module tb_ps2_host_tx;

    localparam int CLK_HZ = 10_000_000;
    localparam int INH_US = 50;
    localparam int TO_MS  = 1;
    localparam int INH_CYC = (CLK_HZ / 1_000_000) * INH_US;   // 500
    localparam int TO_CYC  = (CLK_HZ / 1000) * TO_MS;         // 10000
    localparam int HALF    = 20;                              // device half period

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       dev_clk = 1'b1;
    logic       dev_dat = 1'b1;
    wire        tx_ready, clk_oe, dat_oe, tx_done, tx_error;
    wire        clk_line = dev_clk & ~clk_oe;
    wire        dat_line = dev_dat & ~dat_oe;

    ps2_host_tx #(
        .CLK_FREQ_HZ (CLK_HZ),
        .INHIBIT_US  (INH_US),
        .TIMEOUT_MS  (TO_MS)
    ) dut (
        .CLOCK_50   (clk),
        .RESET      (rst),
        .TX_DATA    (tx_data),
        .TX_VALID   (tx_valid),
        .TX_READY   (tx_ready),
        .PS2_CLK_IN (clk_line),
        .PS2_DAT_IN (dat_line),
        .PS2_CLK_OE (clk_oe),
        .PS2_DAT_OE (dat_oe),
        .TX_DONE    (tx_done),
        .TX_ERROR   (tx_error)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Pulse bookkeeping sampled away from the active edge.
    int   done_cnt = 0;
    int   err_cnt = 0;
    int   both_cnt = 0;
    int   ready_after_cnt = 0;
    int   long_pulse_cnt = 0;
    logic prev_pulse = 1'b0;

    always @(negedge clk) begin
        if (tx_done === 1'b1) done_cnt <= done_cnt + 1;
        if (tx_error === 1'b1) err_cnt <= err_cnt + 1;
        if (tx_done === 1'b1 && tx_error === 1'b1) both_cnt <= both_cnt + 1;
        if (prev_pulse && tx_ready === 1'b1) ready_after_cnt <= ready_after_cnt + 1;
        if (prev_pulse && (tx_done === 1'b1 || tx_error === 1'b1)) long_pulse_cnt <= long_pulse_cnt + 1;
        prev_pulse <= (tx_done === 1'b1) || (tx_error === 1'b1);
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        checks++;
        assert (obs === exp_v) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
        end
    endtask

    // Reference frame: bit0 start, bits1..8 data LSB first, bit9 odd parity, bit10 stop.
    function automatic logic [10:0] model_frame(input logic [7:0] b);
        logic [10:0] f;
        int ones;
        ones = 0;
        f = '0;
        for (int i = 0; i < 8; i++) begin
            ones += int'(b[i]);
            f[i + 1] = b[i];
        end
        f[0]  = 1'b0;
        f[9]  = ((ones % 2) == 0) ? 1'b1 : 1'b0;
        f[10] = 1'b1;
        return f;
    endfunction

    task automatic handshake(input logic [7:0] b, input bit hold);
        int w;
        w = 0;
        while (tx_ready !== 1'b1 && w < 200) begin
            @(negedge clk);
            w++;
        end
        check("ready_before_tx", {31'd0, tx_ready}, 32'd1);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        check("ready_drops", {31'd0, tx_ready}, 32'd0);
        if (hold) tx_data = 8'hAA;
        else tx_valid = 1'b0;
    endtask

    task automatic measure_inhibit(output int n);
        int w;
        w = 0;
        while (clk_oe !== 1'b1 && w < 10) begin
            @(negedge clk);
            w++;
        end
        n = 0;
        while (clk_oe === 1'b1 && n < INH_CYC + 100) begin
            n++;
            @(negedge clk);
        end
    endtask

    // Device generates nfe clock pulses; line data is captured at the end of
    // each low phase. For an acknowledged transfer it pulls data low around
    // the 12th falling edge.
    task automatic device_clock(input int nfe, input bit ack, output logic [10:0] bits);
        bits    = '0;
        bits[0] = dat_line;
        for (int k = 1; k <= nfe; k++) begin
            if (k == 12 && ack) dev_dat = 1'b0;
            repeat (5) @(negedge clk);
            dev_clk = 1'b0;
            if (k == 12) tx_valid = 1'b0;
            repeat (HALF) @(negedge clk);
            if (k <= 10) bits[k] = dat_line;
            dev_clk = 1'b1;
            repeat (HALF) @(negedge clk);
        end
        dev_dat = 1'b1;
    endtask

    task automatic run_tx(input logic [7:0] b, input bit ack, input bit hold,
                          input string name, output logic [10:0] bits);
        int n, d0, e0, r0, l0;
        d0 = done_cnt; e0 = err_cnt; r0 = ready_after_cnt; l0 = long_pulse_cnt;
        handshake(b, hold);
        measure_inhibit(n);
        check({name, "_inhibit_len"}, n, INH_CYC);
        check({name, "_start_bit"}, {31'd0, dat_oe}, 32'd1);
        device_clock(12, ack, bits);
        repeat (12) @(negedge clk);
        check({name, "_frame"}, {21'd0, bits}, {21'd0, model_frame(b)});
        check({name, "_done_pulses"}, done_cnt - d0, ack ? 1 : 0);
        check({name, "_error_pulses"}, err_cnt - e0, ack ? 0 : 1);
        check({name, "_ready_after_pulse"}, ready_after_cnt - r0, 1);
        check({name, "_single_cycle_pulse"}, long_pulse_cnt - l0, 0);
        check({name, "_lines_released"}, {30'd0, clk_oe, dat_oe}, 32'd0);
        $display("TX %s data=%02h ack=%0d frame=%03h expected=%03h done=%0d err=%0d",
                 name, b, ack, bits, model_frame(b), done_cnt - d0, err_cnt - e0);
    endtask

    initial begin
        logic [10:0] bits;
        logic [10:0] f_const;
        logic [7:0]  rb;
        bit          rack;
        int          n, d0, e0;

        // Reset state
        repeat (4) @(negedge clk);
        check("reset_ready", {31'd0, tx_ready}, 32'd0);
        check("reset_oe", {30'd0, clk_oe, dat_oe}, 32'd0);
        check("reset_pulses", {30'd0, tx_done, tx_error}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", {31'd0, tx_ready}, 32'd1);
        $display("TX reset released ready=%0b", tx_ready);

        // 0xF4 with acknowledge
        run_tx(8'hF4, 1'b1, 1'b0, "f4", bits);
        f_const = 11'b10_1111_0100_0;
        check("f4_frame_const", {21'd0, bits}, {21'd0, f_const});

        // 0xED with acknowledge
        run_tx(8'hED, 1'b1, 1'b0, "ed", bits);
        f_const = 11'b11_1110_1101_0;
        check("ed_frame_const", {21'd0, bits}, {21'd0, f_const});

        // Device never clocks: timeout measured from clock release
        d0 = done_cnt; e0 = err_cnt;
        handshake(8'h55, 1'b0);
        measure_inhibit(n);
        check("to_inhibit_len", n, INH_CYC);
        n = 0;
        while (tx_error !== 1'b1 && n < TO_CYC + 100) begin
            @(negedge clk);
            n++;
        end
        check("to_cycles", n, TO_CYC);
        check("to_oe_released", {30'd0, clk_oe, dat_oe}, 32'd0);
        repeat (4) @(negedge clk);
        check("to_error_pulses", err_cnt - e0, 1);
        check("to_no_done", done_cnt - d0, 0);
        $display("TX timeout data=55 cycles=%0d expected=%0d", n, TO_CYC);

        // No acknowledge at the ack edge
        run_tx(8'h3C, 1'b0, 1'b0, "noack", bits);

        // Reset after the 4th data bit
        d0 = done_cnt; e0 = err_cnt;
        handshake(8'h00, 1'b0);
        measure_inhibit(n);
        device_clock(4, 1'b0, bits);
        check("rst_mid_dat_driven", {31'd0, dat_oe}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst_mid_oe", {30'd0, clk_oe, dat_oe}, 32'd0);
        repeat (4) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_mid_ready", {31'd0, tx_ready}, 32'd1);
        repeat (2) @(negedge clk);
        check("rst_mid_no_pulses", (done_cnt - d0) + (err_cnt - e0), 0);
        $display("TX reset mid-transfer oe=%0b%0b", clk_oe, dat_oe);
        run_tx(8'h00, 1'b1, 1'b0, "zero", bits);
        check("zero_parity", {31'd0, bits[9]}, 32'd1);

        // TX_VALID held high with 0xAA during a transfer
        d0 = done_cnt;
        run_tx(8'h3C, 1'b1, 1'b1, "hold", bits);
        repeat (20) @(negedge clk);
        check("hold_no_retrigger", {30'd0, clk_oe, tx_ready}, 32'd1);
        check("hold_one_done", done_cnt - d0, 1);

        // Randomized bytes and acknowledge outcomes
        for (int i = 0; i < 4; i++) begin
            rb   = 8'($urandom_range(0, 255));
            rack = ($urandom_range(0, 3) != 0);
            run_tx(rb, rack, 1'b0, $sformatf("rand%0d", i), bits);
        end

        check("never_done_and_error", both_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/ps2_host_tx.md
PS2_HOST_TX -- requirements
Module: ps2_host_tx

Interface
REQ-001 Parameter CLK_FREQ_HZ, default 50000000, SHALL set the system clock frequency used to derive all timing counts.
REQ-002 Parameter INHIBIT_US, default 100, SHALL set the PS/2 clock-inhibit duration in microseconds.
REQ-003 Parameter TIMEOUT_MS, default 15, SHALL set the maximum time from clock release to transfer completion.
REQ-004 CLOCK_50  in  1  SHALL be the single system clock; one clock domain, synchronous reset, active-high.
REQ-005 RESET  in  1  SHALL be the synchronous, active-high reset, sampled on the CLOCK_50 rising edge.
REQ-006 TX_DATA  in  8  SHALL carry the command byte, captured when TX_VALID and TX_READY are both high.
REQ-007 TX_VALID / TX_READY  in / out  1 / 1  SHALL form a valid/ready request handshake.
REQ-008 PS2_CLK_IN, PS2_DAT_IN  in  1 each  SHALL be the raw, asynchronous line levels.
REQ-009 PS2_CLK_OE, PS2_DAT_OE  out  1 each  SHALL pull the corresponding line low when 1; 0 means released (open-drain, top level ties to PS2_CLK/PS2_DAT).
REQ-010 TX_DONE, TX_ERROR  out  1 each  SHALL be one-cycle completion pulses: success, or no-ack/timeout.

Function
REQ-011 PS2_CLK_IN and PS2_DAT_IN SHALL pass a 2-flop synchronizer; a clock falling edge (fe) is synced sample 1 then 0.
REQ-012 States SHALL be IDLE, INHIBIT, REQ, SHIFT, STOP, ACK, WAIT_IDLE.
REQ-013 IDLE: TX_READY=1, both OE=0; on handshake, latch TX_DATA and odd parity (~^TX_DATA), then go to INHIBIT.
REQ-014 INHIBIT: PS2_CLK_OE=1 for CLK_FREQ_HZ*INHIBIT_US/1e6 cycles (5000 at default); on the last cycle set PS2_DAT_OE=1 (start bit), then go to REQ.
REQ-015 REQ: PS2_CLK_OE=0, PS2_DAT_OE held 1; start the timeout counter; the first fe moves to SHIFT and drives bit0.
REQ-016 SHIFT: each fe drives the next bit of {parity, data[7:0]} LSB first (PS2_DAT_OE = ~bit); the 4-bit bit counter counts 0..8; the fe after parity goes to STOP.
REQ-017 STOP: PS2_DAT_OE=0 (stop bit = 1); the next fe goes to ACK.
REQ-018 ACK: sample synced data at the next fe; 0 means acknowledge, go to WAIT_IDLE; 1 means TX_ERROR pulse and go to IDLE.
REQ-019 WAIT_IDLE: when synced clock and data are both 1, pulse TX_DONE and go to IDLE.
REQ-020 The timeout counter SHALL be ceil(log2(CLK_FREQ_HZ*TIMEOUT_MS/1000)) bits (20 at default, limit 750000).
REQ-021 At the timeout limit in any of REQ through WAIT_IDLE: release both OE the same cycle, pulse TX_ERROR, go to IDLE.
REQ-022 TX_READY SHALL be 0 in every state except IDLE; TX_VALID outside IDLE SHALL be ignored with no queuing.
REQ-023 If fe and the timeout limit coincide, the timeout SHALL win.
REQ-024 Edges seen in IDLE or INHIBIT (device-originated traffic) SHALL be ignored.
REQ-025 TX_DONE and TX_ERROR SHALL never assert in the same cycle.
REQ-026 All outputs SHALL be registered.

Reset
REQ-027 While RESET=1: state=IDLE, PS2_CLK_OE=0, PS2_DAT_OE=0, TX_READY=0, TX_DONE=0, TX_ERROR=0, counters=0, synchronizer flops=1.
REQ-028 TX_READY SHALL rise on the first clock edge after RESET falls.
REQ-029 RESET mid-transfer SHALL release both lines within one cycle, with no TX_DONE or TX_ERROR pulse.

Structure
REQ-030 Shared package ps2_pkg SHALL hold the state encoding, the bit-count width and the timing-count formulas; ps2_rx SHALL reuse it.
REQ-031 Sub-module ps2_sync_edge SHALL contain the synchronizer and fe detector, and ps2_rx SHALL share it.
REQ-032 Target size SHALL be 150-300 lines of RTL.

Verification
REQ-033 Send 0xF4 with a device model ack -> PS2_CLK_OE low for exactly 5000 cycles; line bits 0,0,1,0,1,1,1,1, parity 0, stop 1; one TX_DONE pulse.
REQ-034 Send 0xED -> bits 1,0,1,1,0,1,1,1, parity 1; TX_DONE; TX_READY back to 1 the cycle after.
REQ-035 Device never clocks after release -> TX_ERROR exactly 750000 cycles after REQ entry; both OE = 0.
REQ-036 Device clocks 11 bits but leaves data high at the ack fe -> one TX_ERROR pulse, no TX_DONE.
REQ-037 RESET asserted after the 4th data bit -> both OE = 0 next cycle; no pulses; 0x00 then sends correctly with parity 1.
REQ-038 TX_VALID held high during a transfer with TX_DATA=0xAA -> ignored; only the original byte is sent.
